// File: rtl/block_interleaver_pp.sv
// Ping-pong ROWS x COLS bit interleaver/deinterleaver: one bank fills while the other drains.
// Flush pads a partial block with PAD_BIT; drop_err latches input offered while not ready.
// state  | meaning
// S_IDLE | accepting input bits
// S_PAD  | writing PAD_BIT until the current block wraps
module block_interleaver_pp #(
  parameter int ROWS    = 4,
  parameter int COLS    = 8,
  parameter int MODE    = 0,
  parameter bit PAD_BIT = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic bit_in,
  input  logic valid_in,
  input  logic flush,
  output logic in_ready,
  output logic bit_out,
  output logic valid_out,
  output logic frame_start,
  output logic drop_err
);
  localparam int N      = ROWS * COLS;
  localparam int AW     = $clog2(N);
  // Interleave steps rows fastest; deinterleave steps columns fastest.
  localparam int INNER  = (MODE != 0) ? COLS : ROWS;
  localparam int OUTER  = (MODE != 0) ? ROWS : COLS;
  localparam int STRIDE = (MODE != 0) ? ROWS : COLS;
  localparam int IW     = $clog2(INNER);
  localparam int OW     = $clog2(OUTER);

  typedef enum logic {S_IDLE, S_PAD} pad_state_e;

  pad_state_e        state_q, state_d;
  logic [1:0][N-1:0] bank_q, bank_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic              wr_bank_q, wr_bank_d;
  logic              in_ready_q, in_ready_d;
  logic              drop_err_q, drop_err_d;
  logic              rd_active_q, rd_active_d;
  logic              rd_bank_q, rd_bank_d;
  logic [IW-1:0]     inner_q, inner_d;
  logic [OW-1:0]     outer_q, outer_d;
  logic [AW-1:0]     rd_addr_q, rd_addr_d;
  logic              bit_out_q, bit_out_d;
  logic              valid_out_q, valid_out_d;
  logic              frame_start_q, frame_start_d;
  logic              wr_en, wr_bit, wr_last, blk_full, inner_last, rd_last;

  always_comb begin
    wr_en     = (state_q == S_PAD) || (valid_in && in_ready_q);
    wr_bit    = (state_q == S_PAD) ? PAD_BIT : bit_in;
    wr_last   = (wr_ptr_q == AW'(N - 1));
    blk_full  = wr_en && wr_last;
    bank_d    = bank_q;
    wr_ptr_d  = wr_ptr_q;
    wr_bank_d = wr_bank_q;
    if (wr_en) begin
      bank_d[wr_bank_q][wr_ptr_q] = wr_bit;
      wr_ptr_d = wr_last ? '0 : wr_ptr_q + 1'b1;
      if (wr_last) wr_bank_d = ~wr_bank_q;
    end

    state_d = state_q;
    case (state_q)
      S_IDLE:  if (flush && (wr_ptr_d != '0)) state_d = S_PAD;
      S_PAD:   if (blk_full) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    in_ready_d = (state_d == S_IDLE);
    drop_err_d = drop_err_q | (valid_in & ~in_ready_q);

    // A newly filled bank takes over the read side even on the last read step.
    inner_last  = (inner_q == IW'(INNER - 1));
    rd_last     = inner_last && (outer_q == OW'(OUTER - 1));
    rd_active_d = rd_active_q;
    rd_bank_d   = rd_bank_q;
    inner_d     = inner_q;
    outer_d     = outer_q;
    rd_addr_d   = rd_addr_q;
    if (blk_full) begin
      rd_active_d = 1'b1;
      rd_bank_d   = wr_bank_q;
      inner_d     = '0;
      outer_d     = '0;
      rd_addr_d   = '0;
    end else if (rd_active_q) begin
      if (rd_last) begin
        rd_active_d = 1'b0;
      end else if (inner_last) begin
        inner_d   = '0;
        outer_d   = outer_q + 1'b1;
        rd_addr_d = AW'(outer_q) + 1'b1;
      end else begin
        inner_d   = inner_q + 1'b1;
        rd_addr_d = rd_addr_q + AW'(STRIDE);
      end
    end

    bit_out_d     = rd_active_q & bank_q[rd_bank_q][rd_addr_q];
    valid_out_d   = rd_active_q;
    frame_start_d = rd_active_q && (inner_q == '0) && (outer_q == '0);
  end

  always_ff @(posedge clk) begin
    bank_q <= bank_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      wr_bank_q     <= 1'b0;
      in_ready_q    <= 1'b1;
      drop_err_q    <= 1'b0;
      rd_active_q   <= 1'b0;
      rd_bank_q     <= 1'b0;
      inner_q       <= '0;
      outer_q       <= '0;
      rd_addr_q     <= '0;
      bit_out_q     <= 1'b0;
      valid_out_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      wr_bank_q     <= wr_bank_d;
      in_ready_q    <= in_ready_d;
      drop_err_q    <= drop_err_d;
      rd_active_q   <= rd_active_d;
      rd_bank_q     <= rd_bank_d;
      inner_q       <= inner_d;
      outer_q       <= outer_d;
      rd_addr_q     <= rd_addr_d;
      bit_out_q     <= bit_out_d;
      valid_out_q   <= valid_out_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign bit_out     = bit_out_q;
  assign valid_out   = valid_out_q;
  assign frame_start = frame_start_q;
  assign drop_err    = drop_err_q;

endmodule
